seven_seg_scan_decoder: RTL and testbench
=========================================

// Module: seven_seg_scan_decoder
// PURPOSE
//  Inverse of the hex-to-segment encoder. Monitors a multiplexed 7-seg display bus
//  (active-low segments + per-digit anode strobes) and recovers the hex nibble per digit.
//  Sits beside the display driver as a readback/debug monitor for PPU status displays.
//  Each digit is captured only after its code has been stable for a programmable count.
//  Undefined codes are flagged.
// PARAMETERS
//  NUM_DIGITS       4  number of multiplexed digits / anode lines
//  STABLE_CYCLES    4  consecutive identical samples needed to capture (>=1, <=255)
//  ANODE_ACTIVE_LOW 1  1: an_in bit low selects digit; 0: high selects
// PORTS
//  clk          in   1               system clock, rising edge
//  reset        in   1               asynchronous, active-high
//  seg_in       in   7               segments {g,f,e,d,c,b,a}, bit0=a, active-low, clk-synchronous
//  an_in        in   NUM_DIGITS      digit strobes, polarity per ANODE_ACTIVE_LOW
//  value_out    out  4*NUM_DIGITS    decoded nibbles; digit i at [4i+3:4i]
//  digit_valid  out  NUM_DIGITS      1 = digit i holds a valid decoded code
//  bad_code     out  1               1-cycle pulse: captured pattern is neither hex nor blank
//  bad_digit    out  $clog2(NUM_DIGITS)  index of digit for last bad_code (held)
//  frame_done   out  1               1-cycle pulse: every digit captured since last pulse
// BEHAVIOUR
//  Reset (async, held while high): all outputs 0, state IDLE, counter 0, capture mask 0.
//  Input stage: seg_in/an_in registered once (s_seg, s_an); all logic uses s_* values.
//  Anode normalisation: sel = ANODE_ACTIVE_LOW ? ~s_an : s_an.
//  FSM:
//   IDLE   - sel not one-hot (zero or multiple anodes). Counter=0. No capture.
//            Enter TRACK when sel is one-hot; counter=1.
//   TRACK  - counter++ while sel and s_seg equal the previous cycle.
//            Any change in sel or s_seg: counter=1, stay TRACK (or IDLE if not one-hot).
//            When counter reaches STABLE_CYCLES: capture, go LOCKED.
//   LOCKED - hold; no re-capture while sel/s_seg unchanged.
//            On change: TRACK (counter=1) if one-hot, else IDLE.
//  Capture of digit d = index of the one-hot sel bit:
//   - hex code: value_out[d] = nibble, digit_valid[d] = 1.
//     Codes are 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 c:46 d:21
//     e:06 f:0E (hex, 7-bit).
//   - blank 7F: digit_valid[d] = 0, value_out[d] unchanged, no bad_code.
//   - any other: digit_valid[d] = 0, value_out[d] unchanged, bad_code = 1 for one cycle,
//     bad_digit = d.
//   - capture_mask[d] set in all three cases.
//  Timing: outputs registered. A pattern stable on the pins from edge k is reflected in
//   outputs after edge k+STABLE_CYCLES+1 (1 input stage + STABLE_CYCLES samples).
//  frame_done: pulses the cycle after the capture that makes capture_mask all-ones.
//   Mask clears on that same edge. If that capture is also bad, bad_code and frame_done
//   both pulse.
//  STABLE_CYCLES=1: capture on the first one-hot sample, then LOCKED.
//  Counter saturates at STABLE_CYCLES and never wraps.
//  Reset mid-capture: partial counts and mask discarded. No capture on the first edge
//   after reset deassert (input stage still holds reset values).
// TESTING
//  1) Reset, drive an=1110 seg=30 for 6 clks -> value_out[3:0]=3, digit_valid=0001
//     exactly STABLE_CYCLES+1 edges after drive.
//  2) Scan 4 digits with 1,2,A,F (8 clks each) -> value_out=F_A_2_1, digit_valid=1111,
//     one frame_done pulse after the 4th capture.
//  3) an=1101 seg=7F, then seg=55 -> first: digit_valid[1]=0, no bad_code;
//     second: bad_code pulse, bad_digit=1, value_out[7:4] unchanged.
//  4) Glitch: seg=40 for 3 clks, 24 for 1, 40 for 3 (STABLE_CYCLES=4) -> no capture.
//     Then 40 held 1 more clk -> capture 0.
//  5) an=1100 (two anodes) held 10 clks -> FSM stays IDLE, outputs unchanged.
//  6) Assert reset mid-TRACK and after digits captured -> all outputs 0 immediately
//     (async). Recapture requires full STABLE_CYCLES after release.

Source files
------------

// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder: read-back monitor for a multiplexed 7-seg bus.
// Recovers per-digit hex nibbles once each digit's code has settled.
`timescale 1ns/1ps
module seven_seg_scan_decoder #(
  parameter int NUM_DIGITS       = 4,
  parameter int STABLE_CYCLES    = 4,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    bad_code,
  output logic [DW-1:0]           bad_digit,
  output logic                    frame_done
);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  localparam logic [7:0] SC = 8'(STABLE_CYCLES);

  logic [6:0]            s_seg;
  logic [6:0]            p_seg;
  logic [NUM_DIGITS-1:0] s_an;
  logic [NUM_DIGITS-1:0] sel;
  logic [NUM_DIGITS-1:0] p_sel;
  logic [NUM_DIGITS-1:0] mask;
  logic [NUM_DIGITS-1:0] mask_set;
  state_t                state;
  state_t                state_n;
  logic [7:0]            cnt;
  logic [7:0]            cnt_n;
  logic                  onehot;
  logic                  changed;
  logic                  capture;
  logic [DW-1:0]         dig;
  logic [3:0]            nib;
  logic                  is_hex;
  logic                  is_blank;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_seg <= '0;
      s_an  <= '0;
    end else begin
      s_seg <= seg_in;
      s_an  <= an_in;
    end
  end

  assign sel     = ANODE_ACTIVE_LOW ? ~s_an : s_an;
  assign onehot  = $onehot(sel);
  assign changed = (sel != p_sel) || (s_seg != p_seg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      p_sel <= '0;
      p_seg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      p_sel <= sel;
      p_seg <= s_seg;
    end
  end

  // counter saturates at SC; LOCKED with no change simply holds
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    if (!onehot) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (state == IDLE || changed) begin
      state_n = TRACK;
      cnt_n   = 8'd1;
    end else if (state == TRACK) begin
      cnt_n = (cnt == SC) ? cnt : cnt + 8'd1;
    end
    if (onehot && state_n == TRACK && cnt_n == SC) begin
      capture = 1'b1;
      state_n = LOCKED;
    end
  end

  always_comb begin
    dig = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (sel[i]) dig = DW'(i);
    nib    = 4'h0;
    is_hex = 1'b1;
    unique case (s_seg)
      7'h40:   nib = 4'h0;
      7'h79:   nib = 4'h1;
      7'h24:   nib = 4'h2;
      7'h30:   nib = 4'h3;
      7'h19:   nib = 4'h4;
      7'h12:   nib = 4'h5;
      7'h02:   nib = 4'h6;
      7'h78:   nib = 4'h7;
      7'h00:   nib = 4'h8;
      7'h10:   nib = 4'h9;
      7'h08:   nib = 4'hA;
      7'h03:   nib = 4'hB;
      7'h46:   nib = 4'hC;
      7'h21:   nib = 4'hD;
      7'h06:   nib = 4'hE;
      7'h0E:   nib = 4'hF;
      default: is_hex = 1'b0;
    endcase
    is_blank = (s_seg == 7'h7F);
    mask_set = mask | (NUM_DIGITS'(1) << dig);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_out   <= '0;
      digit_valid <= '0;
      bad_code    <= 1'b0;
      bad_digit   <= '0;
      frame_done  <= 1'b0;
      mask        <= '0;
    end else begin
      bad_code   <= 1'b0;
      frame_done <= 1'b0;
      if (capture) begin
        digit_valid[dig] <= is_hex;
        if (is_hex)
          value_out[4*dig +: 4] <= nib;
        if (!is_hex && !is_blank) begin
          bad_code  <= 1'b1;
          bad_digit <= dig;
        end
        if (&mask_set) begin
          mask       <= '0;
          frame_done <= 1'b1;
        end else begin
          mask <= mask_set;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// tb_seven_seg_scan_decoder: scoreboard bench for the 7-seg read-back
// monitor; expectations are queued per cycle and compared at negedge.
`timescale 1ns/1ps
module tb_seven_seg_scan_decoder;

  localparam int ND = 4;
  localparam int S  = 4;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  an_in  = 4'hF;
  logic [15:0] value_out;
  logic [3:0]  digit_valid;
  logic        bad_code;
  logic [1:0]  bad_digit;
  logic        frame_done;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int          cyc;
    logic [15:0] v;
    logic [3:0]  vl;
    logic        b;
    logic [1:0]  bd;
    logic        fd;
  } exp_t;

  exp_t sbq[$];

  logic [15:0] m_val;
  logic [3:0]  m_vld;
  logic [3:0]  m_mask;
  logic [1:0]  m_bd;

  logic [6:0] codes [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seven_seg_scan_decoder #(
    .NUM_DIGITS(ND),
    .STABLE_CYCLES(S),
    .ANODE_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .seg_in(seg_in),
    .an_in(an_in),
    .value_out(value_out),
    .digit_valid(digit_valid),
    .bad_code(bad_code),
    .bad_digit(bad_digit),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int lookup(input logic [6:0] c);
    int r;
    r = -1;
    for (int i = 0; i < 16; i++)
      if (codes[i] == c) r = i;
    return r;
  endfunction

  task automatic push(input int at);
    exp_t e;
    e.cyc = at;
    e.v   = m_val;
    e.vl  = m_vld;
    e.b   = 1'b0;
    e.bd  = m_bd;
    e.fd  = 1'b0;
    sbq.push_back(e);
  endtask

  task automatic push_cap(input int at, input int d, input logic [6:0] code);
    exp_t e;
    int   n;
    n    = lookup(code);
    e.b  = 1'b0;
    e.fd = 1'b0;
    if (n >= 0) begin
      m_val[4*d +: 4] = 4'(n);
      m_vld[d] = 1'b1;
    end else begin
      m_vld[d] = 1'b0;
      if (code != 7'h7F) begin
        e.b  = 1'b1;
        m_bd = 2'(d);
      end
    end
    m_mask[d] = 1'b1;
    if (m_mask == 4'hF) begin
      e.fd   = 1'b1;
      m_mask = 4'h0;
    end
    e.cyc = at;
    e.v   = m_val;
    e.vl  = m_vld;
    e.bd  = m_bd;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an_in  = a;
    seg_in = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      chk("sb_late", cyc, e.cyc);
    end
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      e = sbq.pop_front();
      chk("value", value_out, e.v);
      chk("valid", digit_valid, e.vl);
      chk("bad_code", bad_code, e.b);
      chk("bad_digit", bad_digit, e.bd);
      chk("frame_done", frame_done, e.fd);
    end else begin
      chk("bad_idle", bad_code, 0);
      chk("fd_idle", frame_done, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [6:0] dcode [4];
    dcode  = '{7'h79, 7'h24, 7'h08, 7'h0E};
    m_val  = '0;
    m_vld  = '0;
    m_mask = '0;
    m_bd   = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_value", value_out, 0);
    chk("rst_valid", digit_valid, 0);
    chk("rst_bad", bad_code, 0);
    chk("rst_bdig", bad_digit, 0);
    chk("rst_fd", frame_done, 0);
    reset = 1'b0;
    drive(4'hF, 7'h7F, 3);

    // single digit, exact latency
    t = cyc;
    push(t + S);
    push_cap(t + S + 1, 0, 7'h30);
    drive(4'b1110, 7'h30, 6);

    // full scan 1,2,A,F
    for (int i = 0; i < 4; i++) begin
      t = cyc;
      push_cap(t + S + 1, i, dcode[i]);
      drive(4'(~(4'b0001 << i)), dcode[i], 8);
    end
    chk("scan_value", value_out, 16'hFA21);
    chk("scan_valid", digit_valid, 4'hF);

    // blank then undefined code on digit 1
    t = cyc;
    push_cap(t + S + 1, 1, 7'h7F);
    drive(4'b1101, 7'h7F, 8);
    t = cyc;
    push_cap(t + S + 1, 1, 7'h55);
    push(t + S + 3);
    drive(4'b1101, 7'h55, 10);
    chk("bad_keep_nib", value_out[7:4], 4'h2);

    // glitch restarts the stability count
    t = cyc;
    push(t + 4);
    push(t + 8);
    push_cap(t + 9, 0, 7'h40);
    drive(4'b1110, 7'h40, 3);
    drive(4'b1110, 7'h24, 1);
    drive(4'b1110, 7'h40, 4);

    // two anodes active: nothing captured
    t = cyc;
    push(t + 5);
    push(t + 10);
    drive(4'b1100, 7'h30, 10);

    // async reset mid-track, then full recapture
    drive(4'b0111, 7'h19, 3);
    reset = 1'b1;
    #1;
    chk("arst_value", value_out, 0);
    chk("arst_valid", digit_valid, 0);
    chk("arst_bad", bad_code, 0);
    chk("arst_bdig", bad_digit, 0);
    chk("arst_fd", frame_done, 0);
    m_val  = '0;
    m_vld  = '0;
    m_mask = '0;
    m_bd   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    t = cyc;
    push(t + S);
    push_cap(t + S + 1, 3, 7'h19);
    drive(4'b0111, 7'h19, 8);

    drive(4'hF, 7'h7F, 4);
    chk("sb_drain", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
